// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: SLL, SRL, SRA, ROL, ROR on a WIDTH-bit operand,
// at most STEP positions per clock, valid/ready on both sides.

module shifter_step #(
    parameter int WIDTH = 32,
    parameter int KW    = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [KW-1:0]    k,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] y
);
    logic [KW-1:0] kc;

    // k == 0 gives kc == WIDTH, so the wrap-around term shifts out completely
    assign kc = KW'(WIDTH) - k;

    always_comb begin
        case (mode)
            3'b000:  y = a << k;
            3'b001:  y = a >> k;
            3'b011:  y = $unsigned($signed(a) >>> k);
            3'b100:  y = (a << k) | (a >> kc);
            3'b101:  y = (a >> k) | (a << kc);
            default: y = a;
        endcase
    end
endmodule

module iterative_shifter #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);
    localparam int           KW     = SHW + 1;
    localparam logic [KW-1:0] STEP_K = KW'(STEP);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [2:0]       mode;
    logic [SHW-1:0]   rem;
    logic [KW-1:0]    k;
    logic [SHW-1:0]   rem_next;
    logic [WIDTH-1:0] stepped;
    logic             legal;

    assign in_ready = (state == IDLE) && rst_n;
    assign out_data = work;
    assign legal    = in_mode inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    assign k        = ({1'b0, rem} < STEP_K) ? {1'b0, rem} : STEP_K;
    assign rem_next = rem - k[SHW-1:0];

    shifter_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a    (work),
        .k    (k),
        .mode (mode),
        .y    (stepped)
    );

    // Zero-shift and illegal requests still spend one cycle in BUSY with k == 0,
    // which keeps the accept-to-valid latency at max(1, ceil(shamt/STEP)).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            mode      <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode  <= in_mode;
                        state <= BUSY;
                        if (legal) begin
                            work    <= in_a;
                            rem     <= in_shamt;
                            out_err <= 1'b0;
                        end else begin
                            work    <= '0;
                            rem     <= '0;
                            out_err <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    work <= stepped;
                    rem  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_shifter.sv
// Directed plus random checks of iterative_shifter against an arithmetic reference.

module tb_iterative_shifter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [4:0]  in_shamt = '0;
    logic [2:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    int n_chk = 0;
    int n_fail = 0;

    iterative_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] m);
        return m == 3'd0 || m == 3'd1 || m == 3'd3 || m == 3'd4 || m == 3'd5;
    endfunction

    function automatic logic [31:0] ref_res(input logic [31:0] a, input int s, input logic [2:0] m);
        logic [63:0] d;
        d = {a, a};
        case (m)
            3'd0: return a << s;
            3'd1: return a >> s;
            3'd3: return 32'($signed(a) >>> s);
            3'd4: begin d = d << s; return d[63:32]; end
            3'd5: begin d = d >> s; return d[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input int s, input logic [2:0] m);
        if (!is_legal(m) || s == 0) return 1;
        return (s + 3) / 4;
    endfunction

    // Issue one request, measure latency, check result, then drain after 'stall' cycles.
    task automatic do_req(input string tag, input logic [31:0] a, input int s,
                          input logic [2:0] m, input int stall);
        int lat;
        bit rdy_busy;
        logic [31:0] held;
        lat = 0;
        rdy_busy = 1'b0;
        for (int c = 0; c < 50 && !in_ready; c++) tick();
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_shamt = 5'(s);
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid) break;
            if (in_ready) rdy_busy = 1'b1;
            tick();
            if (out_valid) lat = c;
        end
        check({tag, "_lat"}, 32'(lat), 32'(ref_lat(s, m)));
        check({tag, "_data"}, out_data, ref_res(a, s, m));
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, !is_legal(m)});
        check({tag, "_rdy_busy"}, {31'd0, rdy_busy | in_ready}, 32'd0);
        held = out_data;
        repeat (stall) tick();
        if (stall > 0) check({tag, "_hold"}, out_data, held);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_fall"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int lat;
        bit rose;

        // reset state
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_err", {31'd0, out_err}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        // directed scenarios
        do_req("sll31",  32'h0000_0001, 31, 3'b000, 0);
        do_req("sra4",   32'h8000_0010, 4,  3'b011, 0);
        do_req("sra31",  32'h8000_0000, 31, 3'b011, 0);
        do_req("srl31",  32'h8000_0000, 31, 3'b001, 0);
        do_req("ror8",   32'h0000_00FF, 8,  3'b101, 0);
        do_req("rol1",   32'h8000_0001, 1,  3'b100, 0);
        do_req("srl0",   32'hDEAD_BEEF, 0,  3'b001, 0);
        do_req("ill010", 32'h1234_5678, 5,  3'b010, 0);
        do_req("legal_after_ill", 32'h1234_5678, 4, 3'b000, 0);
        check("sll31_const", ref_res(32'h1, 31, 3'b000), 32'h8000_0000);

        // backpressure with a second request waiting
        do_req("bp_first_pre", 32'h0F0F_0000, 0, 3'b000, 0);
        in_valid = 1'b1; in_a = 32'hF0F0_0000; in_shamt = 5'd8; in_mode = 3'b001;
        tick();
        in_valid = 1'b1; in_a = 32'h0000_0003; in_shamt = 5'd2; in_mode = 3'b100;
        for (int c = 0; c < 20 && !out_valid; c++) tick();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", out_data, 32'h00F0_F000);
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold", out_data, held);
            check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_vld_fall", {31'd0, out_valid}, 32'd0);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (out_valid) begin lat = c; break; end
        end
        check("bp2_lat", 32'(lat), 32'd1);
        check("bp2_data", out_data, 32'h0000_000C);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // reset in the middle of a long operation
        in_valid = 1'b1; in_a = 32'h0000_0001; in_shamt = 5'd31; in_mode = 3'b000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_err", {31'd0, out_err}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        rose = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) rose = 1'b1;
        end
        check("mid_rst_no_result", {31'd0, rose}, 32'd0);
        do_req("after_rst", 32'hCAFE_F00D, 13, 3'b101, 0);

        // random traffic over all mode codes, with random drain stalls
        for (int i = 0; i < 40; i++) begin
            do_req("rnd", $urandom, int'($urandom_range(0, 31)),
                   3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
